// File: rtl/apx_accuracy_control_csr_if.sv
// Bundle between the core's CSR execute stage, this accuracy-control block and the
// approximate execution units that consume the accuracy_level buses.
interface apx_accuracy_control_csr_if;
    logic        csr_valid;
    logic [11:0] csr_index;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [4:0]  zimm;
    logic        retire;
    logic        csr_hit;
    logic [31:0] csr_read_data;
    logic [7:0]  alu_accuracy;
    logic [7:0]  mul_accuracy;
    logic [7:0]  div_accuracy;
    logic        exact_active;

    modport master (
        output csr_valid, csr_index, funct3, rs1, zimm, retire,
        input  csr_hit, csr_read_data, alu_accuracy, mul_accuracy, div_accuracy, exact_active
    );

    modport slave (
        input  csr_valid, csr_index, funct3, rs1, zimm, retire,
        output csr_hit, csr_read_data, alu_accuracy, mul_accuracy, div_accuracy, exact_active
    );
endinterface

// File: rtl/apx_accuracy_control_csr.sv
// Approximation-control CSRs (APXCTL, EXACTWIN) of the phoeniX core; drives the
// per-unit accuracy_level buses and a retire-counted full-accuracy window.
module apx_accuracy_control_csr #(
    parameter logic [11:0] CSR_BASE  = 12'h800,
    parameter logic [7:0]  RESET_ACC = 8'hFF,
    parameter int          WIN_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    apx_accuracy_control_csr_if.slave     bus
);

    function automatic logic [WIN_WIDTH-1:0] sat_dec(input logic [WIN_WIDTH-1:0] v);
        return (v == '0) ? '0 : v - WIN_WIDTH'(1);
    endfunction

    logic [23:0]          apx_ctl_p1;
    logic [WIN_WIDTH-1:0] win_cnt_p1;

    logic                 hit_ctl;
    logic                 hit_win;
    logic [31:0]          win_ext;
    logic [23:0]          src_ctl;
    logic [WIN_WIDTH-1:0] src_win;
    logic                 src_nz;
    logic                 wr_en;
    logic [23:0]          ctl_wdata;
    logic [WIN_WIDTH-1:0] win_wdata;

    assign hit_ctl = bus.csr_valid && (bus.csr_index == CSR_BASE);
    assign hit_win = bus.csr_valid && (bus.csr_index == CSR_BASE + 12'd1);

    always_comb begin
        win_ext = '0;
        win_ext[WIN_WIDTH-1:0] = win_cnt_p1;
    end

    assign bus.csr_hit       = hit_ctl || hit_win;
    assign bus.csr_read_data = hit_ctl ? {8'h00, apx_ctl_p1} :
                               hit_win ? win_ext : 32'h0;

    // Immediate forms take zimm zero-extended; the operand is sliced per target CSR width.
    assign src_ctl = bus.funct3[2] ? {19'h0, bus.zimm} : bus.rs1[23:0];
    assign src_win = bus.funct3[2] ? WIN_WIDTH'(bus.zimm) : bus.rs1[WIN_WIDTH-1:0];
    assign src_nz  = bus.funct3[2] ? (bus.zimm != 5'h0) : (bus.rs1 != 32'h0);

    always_comb begin
        wr_en     = 1'b0;
        ctl_wdata = apx_ctl_p1;
        win_wdata = win_cnt_p1;
        unique case (bus.funct3[1:0])
            2'b01: begin
                wr_en     = 1'b1;
                ctl_wdata = src_ctl;
                win_wdata = src_win;
            end
            2'b10: begin
                wr_en     = src_nz;
                ctl_wdata = apx_ctl_p1 | src_ctl;
                win_wdata = win_cnt_p1 | src_win;
            end
            2'b11: begin
                wr_en     = src_nz;
                ctl_wdata = apx_ctl_p1 & ~src_ctl;
                win_wdata = win_cnt_p1 & ~src_win;
            end
            default: wr_en = 1'b0;
        endcase
    end

    // State update: reset beats everything, a write to EXACTWIN beats the retire decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            apx_ctl_p1 <= {3{RESET_ACC}};
            win_cnt_p1 <= '0;
        end else begin
            if (hit_ctl && wr_en) begin
                apx_ctl_p1 <= ctl_wdata;
            end
            if (hit_win && wr_en) begin
                win_cnt_p1 <= win_wdata;
            end else if (bus.retire) begin
                win_cnt_p1 <= sat_dec(win_cnt_p1);
            end
        end
    end

    assign bus.exact_active = (win_cnt_p1 != '0);
    assign bus.alu_accuracy = bus.exact_active ? 8'hFF : apx_ctl_p1[7:0];
    assign bus.mul_accuracy = bus.exact_active ? 8'hFF : apx_ctl_p1[15:8];
    assign bus.div_accuracy = bus.exact_active ? 8'hFF : apx_ctl_p1[23:16];

endmodule

// File: tb/tb_apx_accuracy_control_csr.sv
// Directed bench for apx_accuracy_control_csr: CSR ops, exact window, reset priority.
module tb_apx_accuracy_control_csr;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    apx_accuracy_control_csr_if bus ();

    apx_accuracy_control_csr #(
        .CSR_BASE  (12'h800),
        .RESET_ACC (8'hFF),
        .WIN_WIDTH (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.csr_valid = 1'b0;
        bus.csr_index = 12'h000;
        bus.funct3    = 3'b000;
        bus.rs1       = 32'h0;
        bus.zimm      = 5'h0;
        bus.retire    = 1'b0;
    endtask

    // Drive one cycle's inputs, then let the combinational outputs settle.
    task automatic drive(input logic v, input logic [11:0] idx, input logic [2:0] f3,
                         input logic [31:0] r, input logic [4:0] z, input logic ret);
        bus.csr_valid = v;
        bus.csr_index = idx;
        bus.funct3    = f3;
        bus.rs1       = r;
        bus.zimm      = z;
        bus.retire    = ret;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic check_acc(input string tag, input logic [7:0] a, input logic [7:0] m,
                             input logic [7:0] d, input logic act);
        check({tag, "_alu"}, {24'h0, bus.alu_accuracy}, {24'h0, a});
        check({tag, "_mul"}, {24'h0, bus.mul_accuracy}, {24'h0, m});
        check({tag, "_div"}, {24'h0, bus.div_accuracy}, {24'h0, d});
        check({tag, "_act"}, {31'h0, bus.exact_active}, {31'h0, act});
    endtask

    // Read a CSR via CSRRS rs1=0 (no write), optionally with a concurrent retire.
    task automatic read_csr(input string tag, input logic [11:0] idx, input logic ret,
                            input logic [31:0] exp);
        drive(1'b1, idx, 3'b010, 32'h0, 5'h0, ret);
        check(tag, bus.csr_read_data, exp);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // Reset / idle state
        check_acc("rst", 8'hFF, 8'hFF, 8'hFF, 1'b0);
        check("rst_rdata", bus.csr_read_data, 32'h0);
        check("rst_hit", {31'h0, bus.csr_hit}, 32'h0);

        // CSRRW APXCTL; old value visible the same cycle
        drive(1'b1, 12'h800, 3'b001, 32'hAB102030, 5'h0, 1'b0);
        check("rw_hit", {31'h0, bus.csr_hit}, 32'h1);
        check("rw_old", bus.csr_read_data, 32'h00FFFFFF);
        tick();
        check_acc("rw", 8'h30, 8'h20, 8'h10, 1'b0);
        read_csr("rw_readback", 12'h800, 1'b0, 32'h00102030);

        // CSRRSI zimm=0F
        drive(1'b1, 12'h800, 3'b110, 32'hFFFFFFFF, 5'h0F, 1'b0);
        check("rsi_old", bus.csr_read_data, 32'h00102030);
        tick();
        check("rsi_alu", {24'h0, bus.alu_accuracy}, 32'h3F);

        // CSRRC rs1=FF00 clears MUL
        drive(1'b1, 12'h800, 3'b011, 32'h0000FF00, 5'h0, 1'b0);
        check("rc_old", bus.csr_read_data, 32'h0010203F);
        tick();
        check_acc("rc", 8'h3F, 8'h00, 8'h10, 1'b0);

        // CSRRS rs1=0, unsupported funct3, and a miss: none of them write
        read_csr("rs0_old", 12'h800, 1'b0, 32'h0010003F);
        drive(1'b1, 12'h800, 3'b000, 32'hFFFFFFFF, 5'h1F, 1'b0);
        check("unsup_rdata", bus.csr_read_data, 32'h0010003F);
        tick();
        drive(1'b1, 12'h802, 3'b001, 32'h0, 5'h0, 1'b0);
        check("miss_hit", {31'h0, bus.csr_hit}, 32'h0);
        check("miss_rdata", bus.csr_read_data, 32'h0);
        tick();
        read_csr("nowrite_state", 12'h800, 1'b0, 32'h0010003F);

        // Exact window of 3 retires, non-consecutive
        drive(1'b1, 12'h801, 3'b001, 32'h3, 5'h0, 1'b0);
        check("win_old", bus.csr_read_data, 32'h0);
        tick();
        check_acc("win3", 8'hFF, 8'hFF, 8'hFF, 1'b1);
        read_csr("win_ret1", 12'h801, 1'b1, 32'h3);
        check_acc("win2", 8'hFF, 8'hFF, 8'hFF, 1'b1);
        tick();
        read_csr("win_ret2", 12'h801, 1'b1, 32'h2);
        check_acc("win1", 8'hFF, 8'hFF, 8'hFF, 1'b1);
        tick();
        tick();
        read_csr("win_ret3", 12'h801, 1'b1, 32'h1);
        check_acc("win0", 8'h3F, 8'h00, 8'h10, 1'b0);
        read_csr("win_zero", 12'h801, 1'b0, 32'h0);

        // Write beats concurrent decrement
        drive(1'b1, 12'h801, 3'b001, 32'h5, 5'h0, 1'b0);
        tick();
        drive(1'b1, 12'h801, 3'b001, 32'h2, 5'h0, 1'b1);
        check("wr_vs_dec_old", bus.csr_read_data, 32'h5);
        tick();
        read_csr("wr_vs_dec", 12'h801, 1'b0, 32'h2);
        drive(1'b0, 12'h000, 3'b000, 32'h0, 5'h0, 1'b1);
        tick();
        drive(1'b0, 12'h000, 3'b000, 32'h0, 5'h0, 1'b1);
        tick();
        drive(1'b0, 12'h000, 3'b000, 32'h0, 5'h0, 1'b1);
        tick();
        read_csr("sat_zero", 12'h801, 1'b0, 32'h0);
        check("sat_act", {31'h0, bus.exact_active}, 32'h0);

        // Truncation to WIN_WIDTH, then reset with a concurrent APXCTL write
        drive(1'b1, 12'h801, 3'b001, 32'h00030007, 5'h0, 1'b0);
        tick();
        read_csr("trunc", 12'h801, 1'b0, 32'h7);
        reset = 1'b1;
        drive(1'b1, 12'h800, 3'b001, 32'h12345678, 5'h0, 1'b1);
        tick();
        reset = 1'b0;
        #1;
        check_acc("rst_mid", 8'hFF, 8'hFF, 8'hFF, 1'b0);
        read_csr("rst_mid_win", 12'h801, 1'b0, 32'h0);
        read_csr("rst_mid_ctl", 12'h800, 1'b0, 32'h00FFFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apx_accuracy_control_csr.md
Name: apx_accuracy_control_csr

Overview:
- Owns the approximation-control CSRs of the phoeniX core.
- Supplies the accuracy_level buses to the approximate execution units (ALU adder, multiplier, divider). It is the producer side of the accuracy interface those units consume.
- Executes Zicsr accesses (CSRRW/S/C and their immediate forms) to its addresses, returns old values for rd, and drives the per-unit accuracy outputs.
- Also provides a retire-counted "exact window" that temporarily forces full accuracy.

Parameters:
- CSR_BASE, 12'h800: address of APXCTL; the exact-window counter EXACTWIN is at CSR_BASE+1.
- RESET_ACC, 8'hFF: reset value of every accuracy field. 8'hFF = fully accurate.
- WIN_WIDTH, 16: width of the EXACTWIN counter (1..32).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- csr_valid  in  1  CSR instruction in execute this cycle
- csr_index  in  12  CSR address
- funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- rs1  in  32  register source operand
- zimm  in  5  immediate operand (rs1 field)
- retire  in  1  one-cycle pulse per retired instruction
- csr_hit  out  1  csr_valid and csr_index addresses this block
- csr_read_data  out  32  old CSR value, combinational
- alu_accuracy  out  8  to ALU adder accuracy_level
- mul_accuracy  out  8  to multiplier
- div_accuracy  out  8  to divider
- exact_active  out  1  EXACTWIN nonzero

Behaviour:
- Clocking and reset
  - Single clock; every register updates on the rising edge of clk.
  - reset is synchronous and active-high.
- APXCTL layout
  - [7:0] ALU, [15:8] MUL, [23:16] DIV.
  - [31:24] reads 0; writes to it are ignored.
- EXACTWIN layout: [WIN_WIDTH-1:0] count; upper bits read 0.
- Reset state
  - All APXCTL fields = RESET_ACC; EXACTWIN = 0.
  - Outputs: accuracy buses = RESET_ACC, exact_active = 0, csr_hit = 0, csr_read_data = 0.
- Hit and read
  - csr_hit = csr_valid and (csr_index == CSR_BASE or CSR_BASE+1).
  - csr_read_data = pre-write value of the addressed CSR when csr_hit, else 0.
- Write operand and write value
  - Operand src = rs1 for funct3[2]=0, else {27'b0, zimm}.
  - RW: new = src. RS: new = old | src. RC: new = old & ~src.
  - RS/RC with src == 0 perform no write, so a concurrent decrement still applies.
  - RW always writes, including src == 0.
  - Unsupported funct3 (000, 100) with a hit: csr_read_data still valid, no write.
- Latency
  - A write becomes visible on the accuracy outputs and csr_read_data the cycle after csr_valid.
  - Single-cycle, no stall: the block accepts a CSR access every cycle.
- EXACTWIN countdown
  - When count != 0 and retire = 1, count decrements by 1 per cycle. It saturates at 0 and never wraps.
  - A write and a decrement in the same cycle: the write wins and the decrement is dropped.
  - Write values are truncated to WIN_WIDTH bits.
- Output mux
  - exact_active = (count != 0), registered state.
  - While exact_active, all three accuracy outputs = 8'hFF regardless of APXCTL. APXCTL contents are preserved.
  - On the cycle count reaches 0, the outputs return to the APXCTL fields on the following cycle, combinationally from state.
- Reset priority: reset asserted mid-window or concurrently with a write → reset values; the write is lost.
- Misses: a non-hit csr_valid causes no state change.
- Conformance: no latches; every output is defined every cycle (never Z).

Test Plan:
1. Reset, then idle → alu/mul/div_accuracy = 8'hFF, csr_read_data = 0, exact_active = 0.
2. CSRRW 0x800, rs1 = 32'hAB_10_20_30 → read_data = 32'h00FFFFFF in the same cycle. Next cycle: alu = 8'h30, mul = 8'h20, div = 8'h10; readback = 32'h00102030.
3. From state 32'h00102030:
   - CSRRSI zimm = 5'h0F → ALU field 8'h3F.
   - Then CSRRC rs1 = 32'h0000_FF00 → MUL field 8'h00.
   - Then CSRRS rs1 = 0 → no change.
4. Write EXACTWIN = 3, then retire pulses on three non-consecutive cycles:
   - exact_active = 1 and outputs = 8'hFF throughout.
   - After the 3rd retire: count = 0, outputs revert to APXCTL values, exact_active = 0.
5. Count = 5 with retire = 1 and CSRRW EXACTWIN = 2 in the same cycle → next count = 2, not 4. With retire at count = 0 → count stays 0.
6. Synchronous reset asserted while count = 7 and a concurrent CSRRW 0x800 → next cycle: count = 0, all fields 8'hFF.
